// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial word receiver.
package serial_rx_pkg;

    // Receiver sequencing states; PAR is only reachable in parity builds.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAR
    } rx_state_e;

    // Widest word the receiver can be built for.
    localparam int MAX_WORD_W = 64;

    // Value OUT takes after reset, sliced down to WORD_W by the users.
    localparam logic [MAX_WORD_W-1:0] OUT_RESET_VAL = '0;

endpackage

// File: rtl/serial_rx_hold.sv
// One-deep valid/ready holding register for completed words.
// A commit while the register is full and not being drained is dropped
// and flagged with a one-cycle overrun pulse.
module serial_rx_hold
    import serial_rx_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              commit,
    input  logic [WORD_W-1:0] word,
    input  logic              par,
    input  logic              ready,
    output logic [WORD_W-1:0] out,
    output logic              valid,
    output logic              par_err,
    output logic              overrun
);

    logic [WORD_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;
    logic              par_err_q, par_err_d;
    logic              overrun_q, overrun_d;

    // Decide whether a new word loads, is dropped, or the held word drains.
    always_comb begin
        out_d     = out_q;
        valid_d   = valid_q;
        par_err_d = par_err_q;
        overrun_d = 1'b0;
        if (commit) begin
            if (!valid_q || ready) begin
                out_d     = word;
                par_err_d = par;
                valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Register the holding slot and the overrun pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_q     <= OUT_RESET_VAL[WORD_W-1:0];
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign par_err = par_err_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: LSB-first bits on ENABLE strobes,
// words aligned by SYNC, completed words handed to serial_rx_hold.
// Define SERIAL_RX_PARITY_EN to expect a trailing even-parity bit per word.
module serial_word_rx
    import serial_rx_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              DATA,
    input  logic              ENABLE,
    input  logic              SYNC,
    input  logic              READY,
    output logic [WORD_W-1:0] OUT,
    output logic              VALID,
    output logic              PAR_ERR,
    output logic              SYNC_ERR,
    output logic              OVERRUN
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    rx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              sync_err_q, sync_err_d;
    logic              commit;
    logic [WORD_W-1:0] commit_word;
    logic              commit_par;

    // Next-state, bit placement and commit decision for each strobe.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        sync_err_d  = 1'b0;
        commit      = 1'b0;
        commit_word = shift_q;
        commit_par  = 1'b0;
        if (ENABLE) begin
            if (SYNC) begin
                sync_err_d = (state_q != IDLE);
                state_d    = SHIFT;
                idx_d      = ONE_IDX;
                shift_d    = {{(WORD_W-1){1'b0}}, DATA};
            end else begin
                case (state_q)
                    SHIFT: begin
                        shift_d[idx_q] = DATA;
                        if (idx_q == LAST_IDX) begin
                            idx_d = '0;
`ifdef SERIAL_RX_PARITY_EN
                            state_d = PAR;
`else
                            state_d     = IDLE;
                            commit      = 1'b1;
                            commit_word = shift_d;
`endif
                        end else begin
                            idx_d = idx_q + ONE_IDX;
                        end
                    end
`ifdef SERIAL_RX_PARITY_EN
                    PAR: begin
                        state_d     = IDLE;
                        commit      = 1'b1;
                        commit_word = shift_q;
                        commit_par  = DATA ^ (^shift_q);
                    end
`endif
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Receiver state, bit index, shift register and sync-error pulse.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign SYNC_ERR = sync_err_q;

    serial_rx_hold #(
        .WORD_W (WORD_W)
    ) u_hold (
        .clock   (CLOCK),
        .reset_n (RESET_N),
        .commit  (commit),
        .word    (commit_word),
        .par     (commit_par),
        .ready   (READY),
        .out     (OUT),
        .valid   (VALID),
        .par_err (PAR_ERR),
        .overrun (OVERRUN)
    );

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: directed scenarios with literal expectations,
// then randomized framing, checked every cycle against a bit-count model.
module tb_serial_word_rx;

    localparam int W = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int FRAME_BITS = W + 1;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FRAME_BITS = W;
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         data = 1'b0;
    logic         enable = 1'b0;
    logic         sync = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] out_w;
    logic         valid;
    logic         par_err;
    logic         sync_err;
    logic         overrun;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    // Reference model state.
    bit           m_inword = 1'b0;
    int           m_count = 0;
    logic [W-1:0] m_word = '0;
    logic         m_pbit = 1'b0;
    logic [W-1:0] exp_out = '0;
    logic         exp_valid = 1'b0;
    logic         exp_par = 1'b0;
    logic         exp_sync_err = 1'b0;
    logic         exp_overrun = 1'b0;

    // Stimulus shaping knobs.
    int gap_fixed = 0;
    bit gap_rand = 1'b0;
    int ready_mode = 1;

    serial_word_rx #(.WORD_W(W)) dut (
        .CLOCK    (clock),
        .RESET_N  (reset_n),
        .DATA     (data),
        .ENABLE   (enable),
        .SYNC     (sync),
        .READY    (ready),
        .OUT      (out_w),
        .VALID    (valid),
        .PAR_ERR  (par_err),
        .SYNC_ERR (sync_err),
        .OVERRUN  (overrun)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic even_par(input logic [W-1:0] w);
        return logic'($countones(w) % 2);
    endfunction

    // Model: count bits since the last SYNC, commit when a full frame arrived.
    task automatic model_step(input logic rn, input logic en, input logic d, input logic s, input logic r);
        bit   do_commit;
        logic c_par;
        do_commit    = 1'b0;
        c_par        = 1'b0;
        exp_sync_err = 1'b0;
        exp_overrun  = 1'b0;
        if (!rn) begin
            m_inword  = 1'b0;
            m_count   = 0;
            m_word    = '0;
            exp_out   = '0;
            exp_valid = 1'b0;
            exp_par   = 1'b0;
            return;
        end
        if (en) begin
            if (s) begin
                if (m_inword) exp_sync_err = 1'b1;
                m_inword  = 1'b1;
                m_word    = '0;
                m_word[0] = d;
                m_count   = 1;
            end else if (m_inword) begin
                if (m_count < W) m_word[m_count] = d;
                else m_pbit = d;
                m_count++;
                if (m_count == FRAME_BITS) begin
                    do_commit = 1'b1;
                    m_inword  = 1'b0;
                    c_par     = PAR_EN ? (m_pbit ^ even_par(m_word)) : 1'b0;
                end
            end
        end
        if (do_commit) begin
            if (!exp_valid || r) begin
                exp_out   = m_word;
                exp_par   = c_par;
                exp_valid = 1'b1;
            end else begin
                exp_overrun = 1'b1;
            end
        end else if (exp_valid && r) begin
            exp_valid = 1'b0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge and advance the model.
    task automatic apply_stimulus(input logic rn, input logic en, input logic d, input logic s, input logic r);
        @(negedge clock);
        reset_n = rn;
        enable  = en;
        data    = d;
        sync    = s;
        ready   = r;
        @(posedge clock);
        model_step(rn, en, d, s, r);
    endtask

    // Compare every output against the model once per cycle.
    always @(negedge clock) begin
        if (checking) begin
            check_output("valid", 64'(valid), 64'(exp_valid));
            check_output("out", 64'(out_w), 64'(exp_out));
            check_output("sync_err", 64'(sync_err), 64'(exp_sync_err));
            check_output("overrun", 64'(overrun), 64'(exp_overrun));
            if (exp_valid) check_output("par_err", 64'(par_err), 64'(exp_par));
        end
    end

    function automatic logic pick_ready();
        if (ready_mode == 2) return 1'($urandom);
        return (ready_mode == 1);
    endfunction

    task automatic gap_ticks();
        int n;
        n = gap_rand ? int'($urandom_range(0, 2)) : gap_fixed;
        repeat (n) apply_stimulus(1'b1, 1'b0, 1'($urandom), 1'($urandom), pick_ready());
    endtask

    task automatic idle_ticks(input int n);
        repeat (n) apply_stimulus(1'b1, 1'b0, 1'($urandom), 1'($urandom), pick_ready());
    endtask

    task automatic send_bits(input logic [W-1:0] word, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (i != first) gap_ticks();
            apply_stimulus(1'b1, 1'b1, word[i], logic'(i == 0), pick_ready());
        end
    endtask

    task automatic send_parity(input logic [W-1:0] word, input logic bad);
`ifdef SERIAL_RX_PARITY_EN
        gap_ticks();
        apply_stimulus(1'b1, 1'b1, even_par(word) ^ bad, 1'b0, pick_ready());
`else
        if (bad && word == '1) gap_ticks();
`endif
    endtask

    task automatic send_word(input logic [W-1:0] word);
        send_bits(word, 0, W - 1);
        send_parity(word, 1'b0);
    endtask

    initial begin
        logic [W-1:0] w;
        int cut;

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checking = 1'b1;
        #1;
        check_output("reset valid", 64'(valid), 64'h0);
        check_output("reset out", 64'(out_w), 64'h0);
        check_output("reset sync_err", 64'(sync_err), 64'h0);
        check_output("reset overrun", 64'(overrun), 64'h0);

        // Back-to-back strobes, consumer always ready.
        ready_mode = 1;
        send_word(16'hA5C3);
        #1;
        check_output("a5c3 valid", 64'(valid), 64'h1);
        check_output("a5c3 out", 64'(out_w), 64'hA5C3);
        idle_ticks(1);
        #1;
        check_output("a5c3 drained", 64'(valid), 64'h0);

        // Same word with three idle cycles between strobes.
        gap_fixed = 3;
        send_word(16'hA5C3);
        #1;
        check_output("gapped out", 64'(out_w), 64'hA5C3);
        check_output("gapped valid", 64'(valid), 64'h1);
        gap_fixed = 0;
        idle_ticks(2);

        // SYNC arrives at bit 7 of a word, then a clean 0x1234.
        send_bits(16'hFFFF, 0, 6);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        check_output("early sync pulse", 64'(sync_err), 64'h1);
        send_bits(16'h1234, 1, W - 1);
        send_parity(16'h1234, 1'b0);
        #1;
        check_output("resync out", 64'(out_w), 64'h1234);
        idle_ticks(2);

        // Consumer stalled: second word overruns.
        ready_mode = 0;
        send_word(16'hBEEF);
        #1;
        check_output("beef out", 64'(out_w), 64'hBEEF);
        send_word(16'h0F0F);
        #1;
        check_output("overrun pulse", 64'(overrun), 64'h1);
        check_output("held out", 64'(out_w), 64'hBEEF);
        ready_mode = 1;
        idle_ticks(1);
        #1;
        check_output("stall drained", 64'(valid), 64'h0);
        check_output("stall out kept", 64'(out_w), 64'hBEEF);
        idle_ticks(1);

`ifdef SERIAL_RX_PARITY_EN
        send_bits(16'h0001, 0, W - 1);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        check_output("good parity valid", 64'(valid), 64'h1);
        check_output("good parity flag", 64'(par_err), 64'h0);
        send_bits(16'h0001, 0, W - 1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        check_output("bad parity valid", 64'(valid), 64'h1);
        check_output("bad parity flag", 64'(par_err), 64'h1);
        idle_ticks(2);
`endif

        // Reset in the middle of a word while a word is held.
        ready_mode = 0;
        send_word(16'h3C3C);
        send_bits(16'h7777, 0, 8);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check_output("midword reset valid", 64'(valid), 64'h0);
        check_output("midword reset out", 64'(out_w), 64'h0);
        ready_mode = 1;
        send_word(16'h5555);
        #1;
        check_output("post reset out", 64'(out_w), 64'h5555);
        check_output("post reset valid", 64'(valid), 64'h1);
        idle_ticks(2);

        // Randomized framing, gaps, backpressure, stray strobes and resets.
        gap_rand = 1'b1;
        ready_mode = 2;
        for (int n = 0; n < 150; n++) begin
            if (n % 37 == 36) apply_stimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            idle_ticks(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0)
                apply_stimulus(1'b1, 1'b1, 1'($urandom), 1'b0, pick_ready());
            w = W'($urandom);
            cut = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W - 1)) : W;
            if (cut < W) begin
                send_bits(w, 0, cut - 1);
            end else begin
                send_bits(w, 0, W - 1);
                send_parity(w, logic'($urandom_range(0, 3) == 0));
            end
        end
        ready_mode = 1;
        idle_ticks(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
